net_send_tx_arb: RTL and testbench
==================================

# net_send_tx_arb

Packet-atomic two-to-one egress arbiter that merges the two packet streams produced by the ACK_GEN handler (NET_SEND_0, NET_SEND_1) onto the single MAC transmit stream NET_TX. It sits directly downstream of the ep2top handler chain. It grants whole packets with round-robin fairness, registers the output through a 2-entry buffer, and keeps per-source forwarded-packet counters.

## Interface
- DATA_WIDTH, 512, tdata width of all streams
- KEEP_WIDTH, 64, tkeep width (DATA_WIDTH/8)
- CNT_WIDTH, 32, width of packet counters
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- NET_SEND_0_tdata/tkeep/tlast/tvalid  in  DATA_WIDTH/KEEP_WIDTH/1/1  source 0 AXI-stream
- NET_SEND_0_tready  out  1  source 0 ready
- NET_SEND_1_tdata/tkeep/tlast/tvalid  in  DATA_WIDTH/KEEP_WIDTH/1/1  source 1 AXI-stream
- NET_SEND_1_tready  out  1  source 1 ready
- NET_TX_tdata/tkeep/tlast/tvalid  out  DATA_WIDTH/KEEP_WIDTH/1/1  merged stream to MAC
- NET_TX_tready  in  1  MAC ready
- pkt_cnt_0, pkt_cnt_1  out  CNT_WIDTH  packets forwarded from source 0 / source 1

## Operation
- FSM states: IDLE, FWD0, FWD1. Priority pointer `last` (1 bit) records the most recently granted source.
- IDLE: no source ready is asserted. Only source 0 valid -> FWD0. Only source 1 valid -> FWD1. Both valid -> grant source != last. Neither valid -> stay. The transition sets `last` to the granted source.
- FWDx: NET_SEND_x_tready = (buf_count < 2). The other source's tready = 0. An accepted beat is written to the output buffer unchanged (tdata, tkeep, tlast). An accepted beat with tlast=1 returns the FSM to IDLE and increments pkt_cnt_x.
- Packets are never interleaved. Once granted, a source keeps the grant until its tlast beat is accepted, regardless of the other source.
- Output buffer: 2-entry FIFO. NET_TX_tvalid = (buf_count != 0). Data comes from the head entry. A pop happens on NET_TX_tvalid && NET_TX_tready.
- Simultaneous push and pop leaves buf_count unchanged, including at count 1 and count 2. At count 2 a push happens only if a pop also happens. Input tready uses registered buf_count only, so there is no combinational path from NET_TX_tready to NET_SEND_x_tready.
- Counters wrap modulo 2^CNT_WIDTH (all-ones + 1 -> 0).
- The block does not check tkeep. tvalid/tready on a source outside its grant window are ignored.

## Timing
- Reset (rst=0, asynchronous) values: state=IDLE, last=1 (so source 0 wins the first tie), buf_count=0, NET_TX_tvalid=0, NET_SEND_0_tready=0, NET_SEND_1_tready=0, pkt_cnt_0=0, pkt_cnt_1=0. NET_TX_tdata/tkeep/tlast=0.
- Reset mid-packet drops the partial packet and any buffered beats. After release the block restarts from IDLE with no recovery of the dropped data.
- Grant latency: a source valid in IDLE at cycle N sees tready=1 at cycle N+1 (given buffer space).
- Data latency: a beat accepted at cycle N is visible on NET_TX at cycle N+1.
- Throughput: one beat per cycle within a packet. Exactly one idle input cycle (the IDLE state) between consecutive packets.
- Backpressure: NET_TX_tready held low fills the buffer. Input tready drops in the cycle after buf_count reaches 2. No beat is lost or duplicated.
- pkt_cnt_x updates in the cycle after the tlast beat is accepted.

## Test plan
- Single source: source 0 sends a 3-beat packet (tdata 0xA1,0xA2,0xA3, tlast on beat 3), NET_TX_tready=1 -> NET_TX shows the 3 beats in order starting 2 cycles after first tvalid; pkt_cnt_0=1, pkt_cnt_1=0.
- Tie and fairness: both sources continuously valid with 2-beat packets for 4 packets -> output order is src0,src1,src0,src1; each count=2; 1 bubble between packets.
- Atomicity: source 0 sends a 5-beat packet; source 1 asserts valid at beat 2 -> all 5 source-0 beats are contiguous on NET_TX before any source-1 beat; NET_SEND_1_tready stays 0 throughout.
- Backpressure: NET_TX_tready=0 for 6 cycles during an 8-beat packet -> buf_count saturates at 2, source tready deasserts, and all 8 beats emerge intact and in order after release.
- Wrap: with CNT_WIDTH=4, send 17 single-beat packets on source 1 -> pkt_cnt_1=1.
- Async reset mid-packet: assert rst=0 at beat 3 of 6 -> the same cycle shows all outputs at reset values; after release a new source-1 packet forwards normally with pkt_cnt_1=1.

Source files
------------

// File: rtl/net_send_tx_arb.sv
// net_send_tx_arb: packet-atomic round-robin merge of two AXI-streams onto one,
// with a 2-entry registered output buffer and per-source packet counters.
module net_send_tx_arb #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] NET_SEND_0_tdata,
    input  logic [KEEP_WIDTH-1:0] NET_SEND_0_tkeep,
    input  logic                  NET_SEND_0_tlast,
    input  logic                  NET_SEND_0_tvalid,
    output logic                  NET_SEND_0_tready,
    input  logic [DATA_WIDTH-1:0] NET_SEND_1_tdata,
    input  logic [KEEP_WIDTH-1:0] NET_SEND_1_tkeep,
    input  logic                  NET_SEND_1_tlast,
    input  logic                  NET_SEND_1_tvalid,
    output logic                  NET_SEND_1_tready,
    output logic [DATA_WIDTH-1:0] NET_TX_tdata,
    output logic [KEEP_WIDTH-1:0] NET_TX_tkeep,
    output logic                  NET_TX_tlast,
    output logic                  NET_TX_tvalid,
    input  logic                  NET_TX_tready,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_1
);
    typedef enum logic [1:0] {IDLE, FWD0, FWD1} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_last, w_last_nxt;
    logic [1:0]            r_count;
    logic                  r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_data [2];
    logic [KEEP_WIDTH-1:0] r_keep [2];
    logic                  r_tlast [2];
    logic                  w_space, w_acc0, w_acc1, w_push, w_pop, w_in_last;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic [KEEP_WIDTH-1:0] w_in_keep;

    // Space is judged on the registered count only, so MAC ready never reaches source ready.
    assign w_space           = r_count != 2'd2;
    assign NET_SEND_0_tready = (r_state == FWD0) && w_space;
    assign NET_SEND_1_tready = (r_state == FWD1) && w_space;
    assign w_acc0            = NET_SEND_0_tready && NET_SEND_0_tvalid;
    assign w_acc1            = NET_SEND_1_tready && NET_SEND_1_tvalid;
    assign w_push            = w_acc0 || w_acc1;
    assign w_in_data         = w_acc1 ? NET_SEND_1_tdata : NET_SEND_0_tdata;
    assign w_in_keep         = w_acc1 ? NET_SEND_1_tkeep : NET_SEND_0_tkeep;
    assign w_in_last         = w_acc1 ? NET_SEND_1_tlast : NET_SEND_0_tlast;

    assign NET_TX_tvalid = r_count != 2'd0;
    assign NET_TX_tdata  = r_data[r_rd_ptr];
    assign NET_TX_tkeep  = r_keep[r_rd_ptr];
    assign NET_TX_tlast  = r_tlast[r_rd_ptr];
    assign w_pop         = NET_TX_tvalid && NET_TX_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // On a tie the source that was not granted last time wins.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (NET_SEND_0_tvalid && (!NET_SEND_1_tvalid || r_last)) begin
                    w_state_nxt = FWD0;
                    w_last_nxt  = 1'b0;
                end else if (NET_SEND_1_tvalid) begin
                    w_state_nxt = FWD1;
                    w_last_nxt  = 1'b1;
                end
            end
            FWD0:    w_state_nxt = (w_acc0 && NET_SEND_0_tlast) ? IDLE : FWD0;
            FWD1:    w_state_nxt = (w_acc1 && NET_SEND_1_tlast) ? IDLE : FWD1;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_data[0]  <= '0;
            r_data[1]  <= '0;
            r_keep[0]  <= '0;
            r_keep[1]  <= '0;
            r_tlast[0] <= 1'b0;
            r_tlast[1] <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr]  <= w_in_data;
                r_keep[r_wr_ptr]  <= w_in_keep;
                r_tlast[r_wr_ptr] <= w_in_last;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else begin
            if (w_acc0 && NET_SEND_0_tlast)
                pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
            if (w_acc1 && NET_SEND_1_tlast)
                pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
        end
    end
endmodule

// File: tb/tb_net_send_tx_arb.sv
// tb_net_send_tx_arb: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_net_send_tx_arb;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s0_data, s1_data, tx_data;
    logic          s0_last, s0_valid, s0_ready;
    logic          s1_last, s1_valid, s1_ready;
    logic          tx_last, tx_valid, tx_ready;
    logic [3:0]    tx_keep, cnt0, cnt1;
    logic [DW:0]   q0[$], q1[$], exp_q[$];
    int            pop_cyc[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    net_send_tx_arb #(.DATA_WIDTH(DW), .KEEP_WIDTH(DW/8), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .NET_SEND_0_tdata(s0_data), .NET_SEND_0_tkeep(4'hF), .NET_SEND_0_tlast(s0_last),
        .NET_SEND_0_tvalid(s0_valid), .NET_SEND_0_tready(s0_ready),
        .NET_SEND_1_tdata(s1_data), .NET_SEND_1_tkeep(4'hF), .NET_SEND_1_tlast(s1_last),
        .NET_SEND_1_tvalid(s1_valid), .NET_SEND_1_tready(s1_ready),
        .NET_TX_tdata(tx_data), .NET_TX_tkeep(tx_keep), .NET_TX_tlast(tx_last),
        .NET_TX_tvalid(tx_valid), .NET_TX_tready(tx_ready),
        .pkt_cnt_0(cnt0), .pkt_cnt_1(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_tx_valid"}, tx_valid, 0);
        check({nm, "_s0_ready"}, s0_ready, 0);
        check({nm, "_s1_ready"}, s1_ready, 0);
        check({nm, "_tx_data"}, {tx_last, tx_data}, 0);
        check({nm, "_cnt0"}, cnt0, 0);
        check({nm, "_cnt1"}, cnt1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        pop_cyc.delete();
        tx_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_done", n < 300, 1);
        tick();
        tick();
    endtask

    initial begin
        logic f;
        s0_valid = 0; s0_data = 0; s0_last = 0;
        forever begin
            @(negedge clk);
            f = s0_valid && s0_ready && rst;
            @(posedge clk);
            #1;
            if (f && q0.size() != 0) void'(q0.pop_front());
            s0_valid = q0.size() != 0;
            {s0_last, s0_data} = s0_valid ? q0[0] : '0;
        end
    end

    initial begin
        logic f;
        s1_valid = 0; s1_data = 0; s1_last = 0;
        forever begin
            @(negedge clk);
            f = s1_valid && s1_ready && rst;
            @(posedge clk);
            #1;
            if (f && q1.size() != 0) void'(q1.pop_front());
            s1_valid = q1.size() != 0;
            {s1_last, s1_data} = s1_valid ? q1[0] : '0;
        end
    end

    // Monitor: every beat the MAC takes must be the next scoreboard entry.
    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx_unexpected: got %0h expected no beat", {tx_last, tx_data});
            end else
                check("tx_beat", {tx_last, tx_data}, exp_q.pop_front());
        end
    end

    initial begin
        int   n;
        logic bad;
        tx_ready = 1'b1;
        #3 rst = 1'b0;
        #1 check_reset_outputs("por");
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            q0.push_back({i == 2, DW'(32'hA1 + i)});
            exp_q.push_back({i == 2, DW'(32'hA1 + i)});
        end
        n = 0;
        while (!s0_valid && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (!tx_valid && n < 10) begin @(negedge clk); n++; end
        check("single_latency", n, 2);
        drain();
        check("single_cnt0", cnt0, 1);
        check("single_cnt1", cnt1, 0);

        do_reset();
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 2; b++) begin
                if (p % 2 == 0) q0.push_back({b == 1, DW'(p * 2 + b + 1)});
                else            q1.push_back({b == 1, DW'(p * 2 + b + 1)});
                exp_q.push_back({b == 1, DW'(p * 2 + b + 1)});
            end
        drain();
        check("fair_beats", pop_cyc.size(), 8);
        if (pop_cyc.size() == 8) check("fair_span", pop_cyc[7] - pop_cyc[0], 10);
        check("fair_cnt0", cnt0, 2);
        check("fair_cnt1", cnt1, 2);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            q0.push_back({i == 4, DW'(32'h11 + i)});
            exp_q.push_back({i == 4, DW'(32'h11 + i)});
        end
        n = 0;
        while (!s0_ready && n < 10) begin tick(); n++; end
        tick();
        q1.push_back({1'b0, DW'(32'h21)});
        q1.push_back({1'b1, DW'(32'h22)});
        exp_q.push_back({1'b0, DW'(32'h21)});
        exp_q.push_back({1'b1, DW'(32'h22)});
        bad = 1'b0;
        n = 0;
        while (q0.size() != 0 && n < 20) begin @(negedge clk); bad |= s1_ready; n++; end
        check("atomic_s1_ready", bad, 0);
        drain();
        check("atomic_beats", pop_cyc.size(), 7);
        if (pop_cyc.size() == 7) check("atomic_span", pop_cyc[4] - pop_cyc[0], 4);
        check("atomic_cnt0", cnt0, 1);
        check("atomic_cnt1", cnt1, 1);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back({i == 7, DW'(32'h31 + i)});
            exp_q.push_back({i == 7, DW'(32'h31 + i)});
        end
        n = 0;
        while (!tx_valid && n < 10) begin tick(); n++; end
        tx_ready = 1'b0;
        repeat (4) tick();
        check("bp_s0_ready", s0_ready, 0);
        check("bp_tx_valid", tx_valid, 1);
        repeat (2) tick();
        check("bp_no_pop", pop_cyc.size(), 0);
        tx_ready = 1'b1;
        drain();
        check("bp_beats", pop_cyc.size(), 8);
        check("bp_cnt0", cnt0, 1);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            q1.push_back({1'b1, DW'(32'h40 + i)});
            exp_q.push_back({1'b1, DW'(32'h40 + i)});
        end
        drain();
        check("wrap_cnt1", cnt1, 1);
        check("wrap_cnt0", cnt0, 0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            q0.push_back({i == 5, DW'(32'h51 + i)});
            exp_q.push_back({i == 5, DW'(32'h51 + i)});
        end
        n = 0;
        while (pop_cyc.size() < 2 && n < 20) begin tick(); n++; end
        check("arst_pre_beats", pop_cyc.size(), 2);
        rst = 1'b0;
        #1 check_reset_outputs("arst");
        q0.delete();
        exp_q.delete();
        pop_cyc.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        q1.push_back({1'b0, DW'(32'h61)});
        q1.push_back({1'b1, DW'(32'h62)});
        exp_q.push_back({1'b0, DW'(32'h61)});
        exp_q.push_back({1'b1, DW'(32'h62)});
        drain();
        check("arst_beats", pop_cyc.size(), 2);
        check("arst_cnt1", cnt1, 1);
        check("arst_cnt0", cnt0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
